// File: rtl/bcd_inc_arbiter.sv
// Two BCD event counters share one DIGITS-digit incrementor.
// A round-robin FSM handles one increment at a time: IDLE -> CALC -> WB.
module bcd_inc_arbiter #(
  parameter int unsigned DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req0,
  input  logic                  req1,
  input  logic                  clr0,
  input  logic                  clr1,
  output logic                  ack0,
  output logic                  ack1,
  output logic [4*DIGITS-1:0]   cnt0,
  output logic [4*DIGITS-1:0]   cnt1,
  output logic                  ovf0,
  output logic                  ovf1,
  output logic                  busy
);

  localparam int unsigned W = 4 * DIGITS;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] WB   = 2'd2;

  logic [1:0]   state, state_nxt;
  logic         sel, sel_nxt;
  logic         last;
  logic [W-1:0] res;
  logic         res_cy;

  logic [W-1:0]    inc_in;
  logic [W-1:0]    inc_out;
  logic [DIGITS:0] inc_cy;

  assign inc_in = sel ? cnt1 : cnt0;

  // Ripple BCD +1: a digit >= 9 that receives the carry wraps to 0 and passes it on
  always_comb begin
    inc_out   = '0;
    inc_cy    = '0;
    inc_cy[0] = 1'b1;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (inc_cy[i]) begin
        if (inc_in[4*i +: 4] >= 4'd9) begin
          inc_out[4*i +: 4] = 4'd0;
          inc_cy[i+1]       = 1'b1;
        end else begin
          inc_out[4*i +: 4] = 4'(inc_in[4*i +: 4] + 4'd1);
          inc_cy[i+1]       = 1'b0;
        end
      end else begin
        inc_out[4*i +: 4] = inc_in[4*i +: 4];
        inc_cy[i+1]       = 1'b0;
      end
    end
  end

  // Next-state and requester selection
  always_comb begin
    state_nxt = state;
    sel_nxt   = sel;
    case (state)
      IDLE: begin
        if (req0 || req1) begin
          sel_nxt   = (req0 && req1) ? ~last : req1;
          state_nxt = CALC;
        end
      end
      CALC:    state_nxt = WB;
      WB:      state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State, datapath and output registers; a clear overrides a same-edge write-back
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      sel    <= 1'b0;
      last   <= 1'b1;
      res    <= '0;
      res_cy <= 1'b0;
      ack0   <= 1'b0;
      ack1   <= 1'b0;
      busy   <= 1'b0;
      cnt0   <= '0;
      cnt1   <= '0;
      ovf0   <= 1'b0;
      ovf1   <= 1'b0;
    end else begin
      state <= state_nxt;
      sel   <= sel_nxt;
      busy  <= (state_nxt != IDLE);
      ack0  <= (state_nxt == WB) && !sel_nxt;
      ack1  <= (state_nxt == WB) &&  sel_nxt;

      if (state == CALC) begin
        res    <= inc_out;
        res_cy <= inc_cy[DIGITS];
      end

      if (state == WB) begin
        last <= sel;
        if (!sel) begin
          cnt0 <= res;
          if (res_cy) ovf0 <= 1'b1;
        end else begin
          cnt1 <= res;
          if (res_cy) ovf1 <= 1'b1;
        end
      end

      if (clr0) begin
        cnt0 <= '0;
        ovf0 <= 1'b0;
      end
      if (clr1) begin
        cnt1 <= '0;
        ovf1 <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_bcd_inc_arbiter.sv
// Directed bench for bcd_inc_arbiter: per-cycle compare against a transaction-level
// model, plus hand-computed literal expectations for each scenario.
module tb_bcd_inc_arbiter;

  logic        clk = 1'b0;
  logic        reset, req0, req1, clr0, clr1;
  logic        ack0, ack1, ovf0, ovf1, busy;
  logic [11:0] cnt0, cnt1;

  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 0;

  int ack_who[$];
  int ack_cyc[$];
  int busy_cnt;

  // model state
  int          mph;
  logic        msel, mlast, mcy;
  logic [11:0] mres, m_cnt0, m_cnt1;
  logic        m_ovf0, m_ovf1, m_ack0, m_ack1, m_busy;
  logic        pl0;
  logic [11:0] pl_val;

  always #5 clk = ~clk;

  bcd_inc_arbiter #(.DIGITS(3)) dut (
    .clk(clk), .reset(reset), .req0(req0), .req1(req1), .clr0(clr0), .clr1(clr1),
    .ack0(ack0), .ack1(ack1), .cnt0(cnt0), .cnt1(cnt1),
    .ovf0(ovf0), .ovf1(ovf1), .busy(busy)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  // Decimal-digit increment: bump the lowest digit, any digit at or past 9 wraps and carries
  function automatic logic [12:0] bcd_inc(input logic [11:0] v);
    int d[3];
    int c;
    logic [11:0] r;
    for (int i = 0; i < 3; i++) d[i] = int'(v[4*i +: 4]);
    c = 1;
    for (int i = 0; i < 3 && c == 1; i++) begin
      if (d[i] >= 9) d[i] = 0;
      else begin
        d[i] = d[i] + 1;
        c = 0;
      end
    end
    for (int i = 0; i < 3; i++) r[4*i +: 4] = 4'(d[i]);
    return {1'(c), r};
  endfunction

  // Model: one operation occupies three cycles (accept, compute, commit)
  always @(posedge clk) begin
    if (reset) begin
      mph <= 0; msel <= 1'b0; mlast <= 1'b1; mres <= '0; mcy <= 1'b0;
      m_cnt0 <= '0; m_cnt1 <= '0; m_ovf0 <= 1'b0; m_ovf1 <= 1'b0;
      m_ack0 <= 1'b0; m_ack1 <= 1'b0; m_busy <= 1'b0;
    end else begin
      m_ack0 <= 1'b0;
      m_ack1 <= 1'b0;
      if (mph == 0) begin
        if (req0 || req1) begin
          msel   <= (req0 && req1) ? !mlast : req1;
          mph    <= 1;
          m_busy <= 1'b1;
        end
      end else if (mph == 1) begin
        {mcy, mres} <= bcd_inc(msel ? m_cnt1 : m_cnt0);
        mph <= 2;
        if (msel) m_ack1 <= 1'b1;
        else      m_ack0 <= 1'b1;
      end else begin
        if (msel) begin
          m_cnt1 <= mres;
          if (mcy) m_ovf1 <= 1'b1;
        end else begin
          m_cnt0 <= mres;
          if (mcy) m_ovf0 <= 1'b1;
        end
        mlast  <= msel;
        mph    <= 0;
        m_busy <= 1'b0;
      end
      if (clr0) begin m_cnt0 <= '0; m_ovf0 <= 1'b0; end
      if (clr1) begin m_cnt1 <= '0; m_ovf1 <= 1'b0; end
      if (pl0) m_cnt0 <= pl_val;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("ack0", ack0, m_ack0);
      chk("ack1", ack1, m_ack1);
      chk("busy", busy, m_busy);
      chk("cnt0", cnt0, m_cnt0);
      chk("cnt1", cnt1, m_cnt1);
      chk("ovf0", ovf0, m_ovf0);
      chk("ovf1", ovf1, m_ovf1);
    end
  end

  // Requesters hold req until they have seen the requested number of acks
  task automatic run(input int n0, input int n1);
    int r0 = n0;
    int r1 = n1;
    int cyc = 0;
    int budget = 3 * (n0 + n1) + 10;
    ack_who.delete();
    ack_cyc.delete();
    busy_cnt = 0;
    @(negedge clk);
    req0 = (r0 > 0);
    req1 = (r1 > 0);
    while ((r0 > 0 || r1 > 0) && cyc < budget) begin
      @(negedge clk);
      cyc++;
      if (busy) busy_cnt++;
      if (ack0) begin ack_who.push_back(0); ack_cyc.push_back(cyc); if (r0 > 0) r0--; end
      if (ack1) begin ack_who.push_back(1); ack_cyc.push_back(cyc); if (r1 > 0) r1--; end
      req0 = (r0 > 0);
      req1 = (r1 > 0);
    end
    chk("drain", 32'(r0 + r1), 32'd0);
    @(negedge clk);
    if (busy) busy_cnt++;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic pulse_clr(input logic c0, input logic c1);
    @(negedge clk);
    clr0 = c0; clr1 = c1;
    @(negedge clk);
    clr0 = 1'b0; clr1 = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen;
    reset = 1'b1; req0 = 1'b0; req1 = 1'b0; clr0 = 1'b0; clr1 = 1'b0; pl0 = 1'b0; pl_val = '0;
    @(negedge clk);
    @(negedge clk);
    chk_en = 1;
    chk("rst_busy", busy, 1'b0);
    chk("rst_cnt0", cnt0, 12'h000);
    reset = 1'b0;

    // single increment: ack two cycles after accept, busy for two cycles
    run(1, 0);
    chk("t1_cnt0", cnt0, 12'h001);
    chk("t1_cnt1", cnt1, 12'h000);
    chk("t1_ackcyc", 32'(ack_cyc[0]), 32'd2);
    chk("t1_busy", 32'(busy_cnt), 32'd2);

    // wrap from 999
    run(998, 0);
    chk("t2_999", cnt0, 12'h999);
    chk("t2_ovf_pre", ovf0, 1'b0);
    run(1, 0);
    chk("t2_wrap", cnt0, 12'h000);
    chk("t2_ovf0", ovf0, 1'b1);
    chk("t2_ovf1", ovf1, 1'b0);
    run(1, 0);
    chk("t2_after", cnt0, 12'h001);
    chk("t2_sticky", ovf0, 1'b1);

    // multi-digit carries on counter 1
    run(0, 99);
    chk("t4_099", cnt1, 12'h099);
    run(0, 1);
    chk("t4_100", cnt1, 12'h100);
    pulse_clr(1'b0, 1'b1);
    chk("t4_clr", cnt1, 12'h000);
    run(0, 9);
    chk("t4_009", cnt1, 12'h009);
    run(0, 1);
    chk("t4_010", cnt1, 12'h010);

    // clear coinciding with write-back: clear wins, ack still given
    seen = 0;
    @(negedge clk);
    req1 = 1'b1;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      if (ack1) seen = 1;
    end
    clr1 = 1'b1;
    req1 = 1'b0;
    @(negedge clk);
    clr1 = 1'b0;
    chk("t5_ack1", 32'(seen), 32'd1);
    chk("t5_cnt1", cnt1, 12'h000);
    chk("t5_ovf1", ovf1, 1'b0);
    chk("t5_busy", busy, 1'b0);

    // contention from reset: strict alternation starting with requester 0
    @(negedge clk);
    reset = 1'b1; req0 = 1'b1; req1 = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    run(5, 5);
    chk("t3_nacks", 32'(ack_who.size()), 32'd10);
    for (int i = 0; i < ack_who.size(); i++) begin
      chk("t3_order", 32'(ack_who[i]), 32'(i % 2));
      if (i > 0) chk("t3_spacing", 32'(ack_cyc[i] - ack_cyc[i-1]), 32'd3);
    end
    chk("t3_cnt0", cnt0, 12'h005);
    chk("t3_cnt1", cnt1, 12'h005);

    // reset during CALC aborts the operation
    @(negedge clk);
    req0 = 1'b1;
    @(negedge clk);
    chk("t6_calc_busy", busy, 1'b1);
    req0 = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("t6_ack0", ack0, 1'b0);
    chk("t6_busy", busy, 1'b0);
    chk("t6_cnt0", cnt0, 12'h000);
    @(negedge clk);
    chk("t6_ack0_late", ack0, 1'b0);
    chk("t6_cnt0_late", cnt0, 12'h000);

    // illegal digit C normalises to 0 and carries
    @(negedge clk);
    chk_en = 0;
    force dut.cnt0 = 12'h00C;
    pl0 = 1'b1;
    pl_val = 12'h00C;
    @(negedge clk);
    release dut.cnt0;
    pl0 = 1'b0;
    chk_en = 1;
    chk("t6_pre", cnt0, 12'h00C);
    run(1, 0);
    chk("t6_illegal", cnt0, 12'h010);
    chk("t6_ovf0", ovf0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
